// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates interrupt / exception / mret at commit,
// drives one CSR exception write, then one PC redirect with flush.
module trap_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        commit_valid_i,
  input  logic [31:0] commit_pc_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_code_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        we_exc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic [31:0] mtval_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAP_WR  = 2'd1,
    MRET_WR  = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] mstat_q, mstat_d;
  logic [31:0] target_q, target_d;

  logic [2:0]  pend;
  logic        irq_take, exc_take, mret_take, accept, idle;
  logic [31:0] irq_cause, base, vec_target, trap_mstatus, mret_mstatus;

  always_comb begin
    pend      = {irq_ext_i & mie_i[11], irq_sw_i & mie_i[3], irq_timer_i & mie_i[7]};
    irq_take  = mstatus_i[3] & (|pend) & commit_valid_i;
    exc_take  = ~irq_take & commit_valid_i & exc_valid_i;
    mret_take = ~irq_take & commit_valid_i & ~exc_valid_i & mret_i;
    accept    = irq_take | exc_take | mret_take;

    if (pend[2])      irq_cause = 32'h8000_000B;
    else if (pend[1]) irq_cause = 32'h8000_0003;
    else              irq_cause = 32'h8000_0007;

    // Vectored mode only offsets interrupts; exceptions always land on base.
    base       = {mtvec_i[31:2], 2'b00};
    vec_target = (mtvec_i[1:0] == 2'b01) ? base + {26'b0, irq_cause[3:0], 2'b00} : base;

    trap_mstatus        = mstatus_i;
    trap_mstatus[7]     = mstatus_i[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;

    mret_mstatus        = mstatus_i;
    mret_mstatus[3]     = mstatus_i[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b11;
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    mstat_d  = mstat_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (irq_take) begin
          cause_d  = irq_cause;
          epc_d    = commit_pc_i;
          tval_d   = 32'h0;
          mstat_d  = trap_mstatus;
          target_d = vec_target;
          state_d  = TRAP_WR;
        end else if (exc_take) begin
          cause_d  = {28'b0, exc_code_i};
          epc_d    = commit_pc_i;
          tval_d   = exc_tval_i;
          mstat_d  = trap_mstatus;
          target_d = base;
          state_d  = TRAP_WR;
        end else if (mret_take) begin
          // mcause/mtval keep their last captured values as pass-through data.
          epc_d    = mepc_i;
          mstat_d  = mret_mstatus;
          target_d = mepc_i;
          state_d  = MRET_WR;
        end
      end
      TRAP_WR, MRET_WR: state_d = REDIRECT;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cause_q  <= 32'h0;
      epc_q    <= 32'h0;
      tval_q   <= 32'h0;
      mstat_q  <= 32'h0;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      mstat_q  <= mstat_d;
      target_q <= target_d;
    end
  end

  // Strobes are gated by rst_i so a reset cycle never emits a write or redirect.
  always_comb begin
    idle       = (state_q == IDLE);
    busy_o     = ~idle;
    ack_o      = ~rst_i & idle & accept;
    we_exc_o   = ~rst_i & ((state_q == TRAP_WR) | (state_q == MRET_WR));
    redirect_o = ~rst_i & (state_q == REDIRECT);
    flush_o    = ack_o | redirect_o;
    mcause_o   = we_exc_o ? cause_q : 32'h0;
    mepc_o     = we_exc_o ? epc_q : 32'h0;
    mstatus_o  = we_exc_o ? mstat_q : 32'h0;
    mtval_o    = we_exc_o ? tval_q : 32'h0;
    target_o   = redirect_o ? target_q : RESET_PC;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed literal checks plus randomized
// traffic compared each cycle against a cycle-count based reference model.
module tb_trap_ctrl;
  localparam logic [31:0] RPC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cv = 1'b0, exc = 1'b0, mret = 1'b0;
  logic        ie = 1'b0, is = 1'b0, it = 1'b0;
  logic [3:0]  code = 4'h0;
  logic [31:0] pc = 32'h0, tval = 32'h0, ms = 32'h0, mie = 32'h0, mtvec = 32'h0, mepc = 32'h0;

  logic        we_exc, ack, busy, flush, redirect;
  logic [31:0] mcause_o, mepc_o, mstatus_o, mtval_o, target;

  trap_ctrl #(.RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(cv), .commit_pc_i(pc),
    .exc_valid_i(exc), .exc_code_i(code), .exc_tval_i(tval), .mret_i(mret),
    .irq_ext_i(ie), .irq_sw_i(is), .irq_timer_i(it),
    .mstatus_i(ms), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
    .we_exc_o(we_exc), .mcause_o(mcause_o), .mepc_o(mepc_o), .mstatus_o(mstatus_o),
    .mtval_o(mtval_o), .ack_o(ack), .busy_o(busy), .flush_o(flush),
    .redirect_o(redirect), .target_o(target)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: cycles since accept (0 = idle) plus the captured record.
  int          m_phase = 0;
  logic [31:0] m_cause = 0, m_epc = 0, m_tval = 0, m_mstat = 0, m_target = RPC;
  int          ev, irq_code;
  logic [31:0] e_base, e_we, e_red, e_ack;

  always @(negedge clk) begin
    if (armed) begin
      irq_code = 0;
      if (ie && mie[11])      irq_code = 11;
      else if (is && mie[3])  irq_code = 3;
      else if (it && mie[7])  irq_code = 7;
      ev = 0;
      if (cv && ms[3] && irq_code != 0) ev = 1;
      else if (cv && exc)               ev = 2;
      else if (cv && mret)              ev = 3;

      e_we  = (!rst && m_phase == 1) ? 1 : 0;
      e_red = (!rst && m_phase == 2) ? 1 : 0;
      e_ack = (!rst && m_phase == 0 && ev != 0) ? 1 : 0;
      chk("busy", busy, (m_phase != 0) ? 1 : 0);
      chk("ack", ack, e_ack);
      chk("flush", flush, e_ack | e_red);
      chk("we_exc", we_exc, e_we);
      chk("redirect", redirect, e_red);
      chk("mcause", mcause_o, e_we[0] ? m_cause : 0);
      chk("mepc", mepc_o, e_we[0] ? m_epc : 0);
      chk("mstatus", mstatus_o, e_we[0] ? m_mstat : 0);
      chk("mtval", mtval_o, e_we[0] ? m_tval : 0);
      chk("target", target, e_red[0] ? m_target : RPC);

      if (rst) begin
        m_phase = 0; m_cause = 0; m_epc = 0; m_tval = 0; m_mstat = 0; m_target = RPC;
      end else if (m_phase == 0 && ev != 0) begin
        e_base = mtvec & 32'hFFFF_FFFC;
        if (ev == 3) begin
          m_epc    = mepc;
          m_mstat  = (ms & ~32'h0000_1888) | 32'h0000_1880 | (ms[7] ? 32'h8 : 32'h0);
          m_target = mepc;
        end else begin
          m_epc   = pc;
          m_mstat = (ms & ~32'h0000_1888) | 32'h0000_1800 | (ms[3] ? 32'h80 : 32'h0);
          if (ev == 1) begin
            m_cause  = 32'h8000_0000 + irq_code;
            m_tval   = 0;
            m_target = e_base + ((mtvec % 4 == 1) ? irq_code * 4 : 0);
          end else begin
            m_cause  = code;
            m_tval   = tval;
            m_target = e_base;
          end
        end
        m_phase = 1;
      end else if (m_phase != 0) begin
        m_phase = (m_phase + 1) % 3;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    cv = 0; exc = 0; mret = 0; ie = 0; is = 0; it = 0;
  endtask

  int we_count;

  initial begin
    tick(); armed = 1'b1; tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_we", we_exc, 0); chk("rst_ack", ack, 0);
    chk("rst_flush", flush, 0); chk("rst_target", target, RPC); chk("rst_mcause", mcause_o, 0);

    // Exception, code 2
    tick();
    cv = 1; exc = 1; code = 4'd2; pc = 32'h100; tval = 32'hDEAD; mtvec = 32'h8000_0001; ms = 32'h8;
    @(negedge clk); chk("exc_ack", ack, 1); chk("exc_flush", flush, 1);
    tick(); quiet();
    @(negedge clk); chk("exc_we", we_exc, 1); chk("exc_mcause", mcause_o, 32'h2);
    chk("exc_mepc", mepc_o, 32'h100); chk("exc_mtval", mtval_o, 32'hDEAD);
    chk("exc_mstatus", mstatus_o, 32'h1880);
    tick(); @(negedge clk); chk("exc_redirect", redirect, 1); chk("exc_target", target, 32'h8000_0000);
    tick(); @(negedge clk); chk("exc_idle", busy, 0);

    // Timer interrupt, vectored
    tick();
    cv = 1; it = 1; mie = 32'h80; ms = 32'h8; mtvec = 32'h401; pc = 32'h200;
    @(negedge clk); chk("tmr_ack", ack, 1);
    tick(); quiet();
    @(negedge clk); chk("tmr_mcause", mcause_o, 32'h8000_0007); chk("tmr_mepc", mepc_o, 32'h200);
    chk("tmr_mtval", mtval_o, 0);
    tick(); @(negedge clk); chk("tmr_target", target, 32'h41C);
    tick();

    // All interrupts plus exception, held through busy
    cv = 1; ie = 1; is = 1; it = 1; exc = 1; mie = 32'h888; ms = 32'h8; mtvec = 32'h0;
    @(negedge clk); chk("all_ack", ack, 1);
    we_count = 0;
    tick(); @(negedge clk); chk("all_mcause", mcause_o, 32'h8000_000B); chk("all_ack_n1", ack, 0);
    if (we_exc) we_count++;
    tick(); @(negedge clk); chk("all_ack_n2", ack, 0); if (we_exc) we_count++;
    tick(); @(negedge clk); chk("all_ack_n3", ack, 1); if (we_exc) we_count++;
    chk("all_we_pulses", we_count, 1);
    tick(); quiet(); tick(); tick(); tick();

    // mret
    cv = 1; mret = 1; ms = 32'h1880; mepc = 32'h104;
    @(negedge clk); chk("mret_ack", ack, 1);
    tick(); quiet();
    @(negedge clk); chk("mret_mstatus", mstatus_o, 32'h1888); chk("mret_mepc", mepc_o, 32'h104);
    tick(); @(negedge clk); chk("mret_target", target, 32'h104); chk("mret_redirect", redirect, 1);
    tick(); tick();

    // Reset in TRAP_WR
    cv = 1; exc = 1; code = 4'd5; pc = 32'h300;
    tick(); quiet(); rst = 1;
    @(negedge clk); chk("rstw_we", we_exc, 0);
    tick(); rst = 0;
    @(negedge clk); chk("rstw_busy", busy, 0); chk("rstw_we2", we_exc, 0); chk("rstw_red", redirect, 0);
    tick(); @(negedge clk); chk("rstw_red2", redirect, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst   = ($urandom_range(0, 59) == 0);
      cv    = $urandom_range(0, 1);
      exc   = ($urandom_range(0, 3) == 0);
      mret  = ($urandom_range(0, 3) == 0);
      ie    = ($urandom_range(0, 5) == 0);
      is    = ($urandom_range(0, 5) == 0);
      it    = ($urandom_range(0, 5) == 0);
      code  = 4'($urandom);
      pc    = $urandom; tval = $urandom; ms = $urandom; mie = $urandom;
      mtvec = $urandom; mepc = $urandom;
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
